// File: rtl/ram_sync_init.sv
// Single-port synchronous RAM that zeroes itself after reset or on request.
// Reads are pipelined (1 or 2 cycles); same-cycle read/write is read-first or write-first by MODE.
module ram_sync_init #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int RD_LAT = 1,
    parameter int MODE   = 0
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              clr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              busy
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {CLEAR, IDLE} state_t;

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] clr_cnt;
    logic              clr_we;
    logic              wr_fire;
    logic              rd_fire;
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] mem [DEPTH];

    // Requests are only honoured in IDLE, and not in the cycle a clear is requested
    always_comb begin
        state_d = state_q;
        busy    = (state_q == CLEAR);
        clr_we  = 1'b0;
        wr_fire = 1'b0;
        rd_fire = 1'b0;
        case (state_q)
            CLEAR: begin
                clr_we = 1'b1;
                if (clr_cnt == {ADDR_W{1'b1}}) state_d = IDLE;
            end
            IDLE: begin
                if (clr) begin
                    state_d = CLEAR;
                end else begin
                    wr_fire = wr_en;
                    rd_fire = rd_en;
                end
            end
            default: state_d = CLEAR;
        endcase
        if (Rst) begin
            clr_we  = 1'b0;
            wr_fire = 1'b0;
            rd_fire = 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= CLEAR;
            clr_cnt <= '0;
        end else begin
            state_q <= state_d;
            clr_cnt <= (state_q == CLEAR) ? clr_cnt + ADDR_W'(1) : '0;
        end
    end

    always_ff @(posedge Clk) begin
        if (clr_we) mem[clr_cnt] <= '0;
        else if (wr_fire) mem[Addr] <= wr_data;
    end

    // Read data is captured at acceptance so a following clear cannot corrupt it
    assign rd_word = (MODE == 1 && wr_fire) ? wr_data : mem[Addr];

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic              vld_p0;
            logic [DATA_W-1:0] data_p0;

            // Stage p0: capture accepted word
            always_ff @(posedge Clk) begin
                data_p0 <= rd_word;
            end

            // Stage p1: output register, holds while no read is delivered
            always_ff @(posedge Clk) begin
                if (Rst) begin
                    vld_p0   <= 1'b0;
                    rd_valid <= 1'b0;
                    rd_data  <= '0;
                end else begin
                    vld_p0   <= rd_fire;
                    rd_valid <= vld_p0;
                    if (vld_p0) rd_data <= data_p0;
                end
            end
        end else begin : g_lat1
            // Stage p0: output register, holds while no read is delivered
            always_ff @(posedge Clk) begin
                if (Rst) begin
                    rd_valid <= 1'b0;
                    rd_data  <= '0;
                end else begin
                    rd_valid <= rd_fire;
                    if (rd_fire) rd_data <= rd_word;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_ram_sync_init.sv
// Directed bench: one read-first/latency-1 instance and one write-first/latency-2
// instance share the same stimulus and are each checked against hand-derived values.
module tb_ram_sync_init;

    logic       Clk;
    logic       Rst;
    logic       wr_en;
    logic       rd_en;
    logic [3:0] Addr;
    logic [7:0] wr_data;
    logic       clr;
    logic [7:0] rd_data1, rd_data2;
    logic       rd_valid1, rd_valid2;
    logic       busy1, busy2;

    int checks = 0;
    int errors = 0;
    logic [7:0] pattern [16];

    ram_sync_init #(.DATA_W(8), .ADDR_W(4), .RD_LAT(1), .MODE(0)) dut1 (
        .Clk(Clk), .Rst(Rst), .wr_en(wr_en), .rd_en(rd_en), .Addr(Addr),
        .wr_data(wr_data), .clr(clr), .rd_data(rd_data1), .rd_valid(rd_valid1),
        .busy(busy1)
    );

    ram_sync_init #(.DATA_W(8), .ADDR_W(4), .RD_LAT(2), .MODE(1)) dut2 (
        .Clk(Clk), .Rst(Rst), .wr_en(wr_en), .rd_en(rd_en), .Addr(Addr),
        .wr_data(wr_data), .clr(clr), .rd_data(rd_data2), .rd_valid(rd_valid2),
        .busy(busy2)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        wr_en = 1'b1; Addr = a; wr_data = d;
        cyc();
        wr_en = 1'b0;
    endtask

    // Both instances return the same word: lat1 one cycle after acceptance, lat2 two
    task automatic do_read(input string tag, input logic [3:0] a, input logic [7:0] exp);
        rd_en = 1'b1; Addr = a;
        cyc();
        rd_en = 1'b0;
        check({tag, "_v1"}, rd_valid1, 1);
        check({tag, "_d1"}, rd_data1, exp);
        check({tag, "_v2_early"}, rd_valid2, 0);
        cyc();
        check({tag, "_v1_drop"}, rd_valid1, 0);
        check({tag, "_d1_hold"}, rd_data1, exp);
        check({tag, "_v2"}, rd_valid2, 1);
        check({tag, "_d2"}, rd_data2, exp);
        cyc();
        check({tag, "_v2_drop"}, rd_valid2, 0);
    endtask

    task automatic wait_clear(input string tag);
        for (int i = 0; i < 16; i++) begin
            check({tag, "_busy1"}, busy1, 1);
            check({tag, "_busy2"}, busy2, 1);
            cyc();
        end
        check({tag, "_idle1"}, busy1, 0);
        check({tag, "_idle2"}, busy2, 0);
    endtask

    initial begin
        Rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; Addr = '0; wr_data = '0; clr = 1'b0;

        // Reset for two cycles, then the self-clear
        cyc(); cyc();
        check("rst_busy1", busy1, 1);
        check("rst_busy2", busy2, 1);
        check("rst_vld1", rd_valid1, 0);
        check("rst_vld2", rd_valid2, 0);
        check("rst_data1", rd_data1, 0);
        check("rst_data2", rd_data2, 0);
        Rst = 1'b0;
        wait_clear("rst_clear");
        for (int i = 0; i < 16; i++) do_read("rst_zero", 4'(i), 8'h00);

        // Write then read
        wr(4'd3, 8'hA5);
        do_read("wr_rd", 4'd3, 8'hA5);

        // Same-cycle read/write collision
        wr(4'd5, 8'h11);
        wr_en = 1'b1; rd_en = 1'b1; Addr = 4'd5; wr_data = 8'h22;
        cyc();
        wr_en = 1'b0; rd_en = 1'b0;
        check("col_v1", rd_valid1, 1);
        check("col_old_d1", rd_data1, 8'h11);
        check("col_v2_early", rd_valid2, 0);
        cyc();
        check("col_v2", rd_valid2, 1);
        check("col_new_d2", rd_data2, 8'h22);
        do_read("col_after", 4'd5, 8'h22);

        // Streaming reads
        for (int i = 0; i < 16; i++) begin
            pattern[i] = 8'($urandom);
            wr(4'(i), pattern[i]);
        end
        for (int i = 0; i < 16; i++) begin
            rd_en = 1'b1; Addr = 4'(i);
            cyc();
            check("stream_v1", rd_valid1, 1);
            check("stream_d1", rd_data1, pattern[i]);
            if (i == 0) begin
                check("stream_v2_first", rd_valid2, 0);
            end else begin
                check("stream_v2", rd_valid2, 1);
                check("stream_d2", rd_data2, pattern[i-1]);
            end
        end
        rd_en = 1'b0;
        cyc();
        check("stream_v1_end", rd_valid1, 0);
        check("stream_v2_last", rd_valid2, 1);
        check("stream_d2_last", rd_data2, pattern[15]);
        cyc();

        // Clear with a colliding write, then writes/reads hammered during busy
        clr = 1'b1; wr_en = 1'b1; Addr = 4'd2; wr_data = 8'hEE;
        cyc();
        clr = 1'b0;
        for (int i = 0; i < 16; i++) begin
            check("clr_busy1", busy1, 1);
            check("clr_busy2", busy2, 1);
            wr_en = 1'b1; rd_en = 1'b1; Addr = 4'(i + 15); wr_data = 8'hFF;
            cyc();
            check("clr_no_rd1", rd_valid1, 0);
        end
        wr_en = 1'b0; rd_en = 1'b0;
        check("clr_idle1", busy1, 0);
        check("clr_idle2", busy2, 0);
        check("clr_no_rd2", rd_valid2, 0);
        for (int i = 0; i < 16; i++) do_read("clr_zero", 4'(i), 8'h00);

        // Reset in the middle of a clear restarts it from address 0
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        repeat (9) cyc();
        check("midclr_busy", busy1, 1);
        Rst = 1'b1;
        cyc();
        Rst = 1'b0;
        wait_clear("midclr");

        // Reset discards a read still in flight
        wr(4'd3, 8'hA5);
        rd_en = 1'b1; Addr = 4'd3;
        cyc();
        rd_en = 1'b0;
        check("flush_v1", rd_valid1, 1);
        check("flush_d1", rd_data1, 8'hA5);
        Rst = 1'b1;
        cyc();
        Rst = 1'b0;
        check("flush_v2", rd_valid2, 0);
        check("flush_d1_rst", rd_data1, 0);
        check("flush_d2_rst", rd_data2, 0);
        cyc();
        check("flush_v2_late", rd_valid2, 0);
        repeat (15) cyc();
        check("flush_idle", busy1, 0);
        do_read("flush_zero", 4'd3, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_sync_init.md
RAM_SYNC_INIT -- requirements
Module: ram_sync_init

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, data word width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 4, address width; DEPTH = 2**ADDR_W words.
REQ-003 The block SHALL have parameter RD_LAT, default 1, read latency in cycles; legal values 1 and 2.
REQ-004 The block SHALL have parameter MODE, default 0; 0 = read-first, 1 = write-first on same-cycle read/write.
REQ-005 The block SHALL have one clock; reset is synchronous and active-high: port Clk, input, 1 bit, clock; all state updates on rising edge.
REQ-006 The block SHALL have port Rst, input, 1 bit, synchronous active-high reset.
REQ-007 The block SHALL have port wr_en, input, 1 bit, write request.
REQ-008 The block SHALL have port rd_en, input, 1 bit, read request.
REQ-009 The block SHALL have port Addr, input, ADDR_W bits, shared read/write address.
REQ-010 The block SHALL have port wr_data, input, DATA_W bits, write data.
REQ-011 The block SHALL have port clr, input, 1 bit, request to zero the whole array.
REQ-012 The block SHALL have port rd_data, output, DATA_W bits, read data.
REQ-013 The block SHALL have port rd_valid, output, 1 bit, one-cycle strobe qualifying rd_data.
REQ-014 The block SHALL have port busy, output, 1 bit, high while the array is being cleared.

Function
REQ-015 The block SHALL implement a two-state FSM, CLEAR and IDLE; busy SHALL be 1 in CLEAR and 0 in IDLE.
REQ-016 In CLEAR, the block SHALL write zero to address clr_cnt each cycle, with clr_cnt counting from 0 to DEPTH-1, then enter IDLE; a clear SHALL take exactly DEPTH cycles.
REQ-017 In IDLE, clr=1 SHALL enter CLEAR with clr_cnt=0 on the next edge; wr_en and rd_en SHALL be ignored in that cycle.
REQ-018 In CLEAR, wr_en, rd_en and clr SHALL be ignored; clr SHALL NOT restart the counter.
REQ-019 In IDLE, wr_en=1 SHALL write wr_data to mem[Addr] at the rising edge.
REQ-020 In IDLE, rd_en=1 SHALL accept a read of mem[Addr]; rd_valid SHALL pulse high exactly RD_LAT cycles after the accepting edge, with rd_data valid in that cycle.
REQ-021 Reads SHALL be fully pipelined: back-to-back rd_en SHALL give back-to-back rd_valid in the same order.
REQ-022 For wr_en=1 and rd_en=1 in the same IDLE cycle, the write SHALL occur; the read SHALL return the old word when MODE=0 and wr_data when MODE=1.
REQ-023 rd_data SHALL hold its last value while rd_valid=0.
REQ-024 Data for a read accepted before a clear begins SHALL be captured at acceptance and delivered normally during CLEAR.
REQ-025 Addr SHALL wrap naturally; no out-of-range address exists.

Reset
REQ-026 On Rst=1 at an edge, the block SHALL set rd_data=0, rd_valid=0, busy=1, FSM=CLEAR, clr_cnt=0, and flush the read pipeline.
REQ-027 After Rst deasserts, busy SHALL fall after exactly DEPTH cycles, and every word SHALL then read 0.
REQ-028 Rst asserted mid-clear or mid-read SHALL restart the clear from address 0 and discard pending reads.

Verification
REQ-029 The bench SHALL check reset: Rst for 2 cycles then release -> busy=1 for 16 cycles, then 0; reading all 16 addresses returns 8'h00.
REQ-030 The bench SHALL check write then read: write 8'hA5 to 3, then read 3 with RD_LAT=1 -> rd_valid one cycle later with rd_data=8'hA5; repeat with RD_LAT=2 -> two cycles later.
REQ-031 The bench SHALL check collision: mem[5]=8'h11, then wr_en=rd_en=1 at 5 with wr_data=8'h22 -> rd_data=8'h11 (MODE=0) or 8'h22 (MODE=1); a later read of 5 returns 8'h22.
REQ-032 The bench SHALL check streaming: fill 0..15 with random data, then 16 consecutive reads -> 16 consecutive rd_valid pulses with matching data in order.
REQ-033 The bench SHALL check clear: pulse clr with wr_en=1 in the same cycle -> no write; busy for 16 cycles; all words 0; wr_en during busy has no effect.
REQ-034 The bench SHALL check reset mid-clear: Rst at clr_cnt=9 -> busy stays high and falls 16 cycles after Rst deasserts.
